// File: rtl/proc_defs.sv
// Shared definitions for the execute stage: ALU op codes, default widths,
// FSM state encoding and the pass-through control bundle.
package proc_defs;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_REGADDR = 3;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_DIVU = 4'd9;
    localparam logic [3:0] OP_REMU = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic branch;
        logic reg_dst;
        logic reg_write;
        logic mem_to_reg;
    } ctrl_t;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiply / restoring divide, one step per cycle for WIDTH cycles.
// acc_q is the product accumulator (MUL) or partial remainder (DIV/REM).
module muldiv_iter
    import proc_defs::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int CW = $clog2(WIDTH);

    logic             active_q;
    logic [CW-1:0]    cnt_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] acc_q, q_q, m_q;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] diff;

    // Extra headroom bit keeps the divide-by-zero case non-negative on every step.
    always_comb begin
        rem_sh   = {acc_q, q_q[WIDTH-1]};
        diff     = {1'b0, rem_sh} - {2'b00, m_q};
        done_o   = active_q && (cnt_q == CW'(WIDTH-1));
        result_o = (op_q == OP_DIVU) ? q_q : acc_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            m_q      <= '0;
        end else if (abort_i) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else if (start_i) begin
            active_q <= 1'b1;
            cnt_q    <= '0;
            op_q     <= op_i;
            acc_q    <= '0;
            if (op_i == OP_MUL) begin
                m_q <= a_i;
                q_q <= b_i;
            end else begin
                q_q <= a_i;
                m_q <= b_i;
            end
        end else if (active_q) begin
            cnt_q <= done_o ? '0 : cnt_q + CW'(1);
            if (done_o)
                active_q <= 1'b0;
            if (op_q == OP_MUL) begin
                if (q_q[0])
                    acc_q <= acc_q + m_q;
                m_q <= m_q << 1;
                q_q <= q_q >> 1;
            end else if (!diff[WIDTH+1]) begin
                acc_q <= diff[WIDTH-1:0];
                q_q   <= {q_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_q <= rem_sh[WIDTH-1:0];
                q_q   <= {q_q[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, iterative mul/div sequencing with a busy
// stall, flush handling and the EX/MEM pipeline register.
module ex_stage
    import proc_defs::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int REGADDR = DEF_REGADDR
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               inValid,
    input  logic               flush,
    input  logic [WIDTH-1:0]   readData1,
    input  logic [WIDTH-1:0]   readData2,
    input  logic [WIDTH-1:0]   immediate,
    input  logic               ALUSrc,
    input  logic [3:0]         ALUOp,
    input  logic               MemRead,
    input  logic               MemWrite,
    input  logic               Branch,
    input  logic               RegDst,
    input  logic               RegWrite,
    input  logic               MemtoReg,
    input  logic [REGADDR-1:0] writeReg,
    output logic               busy,
    output logic               outValid,
    output logic [WIDTH-1:0]   resultALU,
    output logic               Zero,
    output logic [WIDTH-1:0]   readData2Out,
    output logic               MemReadOut,
    output logic               MemWriteOut,
    output logic               BranchOut,
    output logic               RegDstOut,
    output logic               RegWriteOut,
    output logic               MemtoRegOut,
    output logic [REGADDR-1:0] writeRegOut
);

    state_t             state_q;
    logic               busy_q, valid_q, zero_q;
    logic [WIDTH-1:0]   res_q, rd2_q, rd2_hold_q;
    logic [REGADDR-1:0] wr_q, wr_hold_q;
    ctrl_t              ctrl_in, ctrl_q, ctrl_hold_q;

    logic [WIDTH-1:0]   op_b, alu_d, md_result;
    logic               md_start, md_done;

    assign ctrl_in = {MemRead, MemWrite, Branch, RegDst, RegWrite, MemtoReg};

    always_comb begin
        op_b = ALUSrc ? immediate : readData2;
        unique case (ALUOp)
            OP_ADD:  alu_d = readData1 + op_b;
            OP_SUB:  alu_d = readData1 - op_b;
            OP_AND:  alu_d = readData1 & op_b;
            OP_OR:   alu_d = readData1 | op_b;
            OP_XOR:  alu_d = readData1 ^ op_b;
            OP_SLT:  alu_d = {{(WIDTH-1){1'b0}}, $signed(readData1) < $signed(op_b)};
            OP_SLL:  alu_d = readData1 << op_b[3:0];
            OP_SRL:  alu_d = readData1 >> op_b[3:0];
            default: alu_d = '0;
        endcase
    end

    assign md_start = (state_q == S_IDLE) && inValid && !flush && is_muldiv(ALUOp);

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clock    (clock),
        .reset    (reset),
        .start_i  (md_start),
        .abort_i  (flush),
        .op_i     (ALUOp),
        .a_i      (readData1),
        .b_i      (op_b),
        .done_o   (md_done),
        .result_o (md_result)
    );

    // Data outputs only move when a result is written; outValid is cleared by default.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            zero_q      <= 1'b0;
            res_q       <= '0;
            rd2_q       <= '0;
            wr_q        <= '0;
            ctrl_q      <= '0;
            rd2_hold_q  <= '0;
            wr_hold_q   <= '0;
            ctrl_hold_q <= '0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (inValid && !flush) begin
                        if (is_muldiv(ALUOp)) begin
                            state_q     <= S_ITER;
                            busy_q      <= 1'b1;
                            rd2_hold_q  <= readData2;
                            wr_hold_q   <= writeReg;
                            ctrl_hold_q <= ctrl_in;
                        end else begin
                            valid_q <= 1'b1;
                            res_q   <= alu_d;
                            zero_q  <= (alu_d == '0);
                            rd2_q   <= readData2;
                            wr_q    <= writeReg;
                            ctrl_q  <= ctrl_in;
                        end
                    end
                end
                S_ITER: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (md_done) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    if (!flush) begin
                        valid_q <= 1'b1;
                        res_q   <= md_result;
                        zero_q  <= (md_result == '0);
                        rd2_q   <= rd2_hold_q;
                        wr_q    <= wr_hold_q;
                        ctrl_q  <= ctrl_hold_q;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign outValid     = valid_q;
    assign resultALU    = res_q;
    assign Zero         = zero_q;
    assign readData2Out = rd2_q;
    assign writeRegOut  = wr_q;
    assign MemReadOut   = ctrl_q.mem_read;
    assign MemWriteOut  = ctrl_q.mem_write;
    assign BranchOut    = ctrl_q.branch;
    assign RegDstOut    = ctrl_q.reg_dst;
    assign RegWriteOut  = ctrl_q.reg_write;
    assign MemtoRegOut  = ctrl_q.mem_to_reg;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: table of single-cycle ops plus mul/div, flush and reset
// sequences; expected results are queued at issue and checked on outValid.
module tb_ex_stage;
    import proc_defs::*;

    logic        clock = 1'b0;
    logic        reset, inValid, flush, ALUSrc;
    logic [15:0] readData1, readData2, immediate;
    logic [3:0]  ALUOp;
    logic [5:0]  ctrl_in;
    logic [2:0]  writeReg;
    logic        MemRead, MemWrite, Branch, RegDst, RegWrite, MemtoReg;
    logic        busy, outValid, Zero;
    logic [15:0] resultALU, readData2Out;
    logic        MemReadOut, MemWriteOut, BranchOut, RegDstOut, RegWriteOut, MemtoRegOut;
    logic [2:0]  writeRegOut;
    logic [5:0]  ctrl_o;

    assign {MemRead, MemWrite, Branch, RegDst, RegWrite, MemtoReg} = ctrl_in;
    assign ctrl_o = {MemReadOut, MemWriteOut, BranchOut, RegDstOut, RegWriteOut, MemtoRegOut};

    ex_stage dut (
        .clock(clock), .reset(reset), .inValid(inValid), .flush(flush),
        .readData1(readData1), .readData2(readData2), .immediate(immediate),
        .ALUSrc(ALUSrc), .ALUOp(ALUOp),
        .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch),
        .RegDst(RegDst), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .writeReg(writeReg), .busy(busy), .outValid(outValid),
        .resultALU(resultALU), .Zero(Zero), .readData2Out(readData2Out),
        .MemReadOut(MemReadOut), .MemWriteOut(MemWriteOut), .BranchOut(BranchOut),
        .RegDstOut(RegDstOut), .RegWriteOut(RegWriteOut), .MemtoRegOut(MemtoRegOut),
        .writeRegOut(writeRegOut)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] res;
        logic        zero;
        logic [15:0] rd2;
        logic [5:0]  ctrl;
        logic [2:0]  wr;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic        src;
        logic [15:0] a, b, imm;
        logic [5:0]  ctrl;
        logic [2:0]  wr;
        logic [15:0] res;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[15];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, expv);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic src, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] imm,
                         input logic [5:0] c, input logic [2:0] wr);
        inValid = 1'b1; ALUOp = op; ALUSrc = src; readData1 = a; readData2 = b;
        immediate = imm; ctrl_in = c; writeReg = wr;
    endtask

    task automatic push(input logic [15:0] res, input logic [15:0] rd2,
                        input logic [5:0] c, input logic [2:0] wr);
        sb.push_back('{res, (res == 16'h0000), rd2, c, wr});
    endtask

    always @(negedge clock) begin
        if (!reset && outValid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out res=%h", resultALU);
            end else begin
                mon_e = sb.pop_front();
                if (resultALU !== mon_e.res || Zero !== mon_e.zero || readData2Out !== mon_e.rd2 ||
                    ctrl_o !== mon_e.ctrl || writeRegOut !== mon_e.wr) begin
                    errors++;
                    $display("FAIL result got=%h/%b/%h/%b/%0d exp=%h/%b/%h/%b/%0d",
                             resultALU, Zero, readData2Out, ctrl_o, writeRegOut,
                             mon_e.res, mon_e.zero, mon_e.rd2, mon_e.ctrl, mon_e.wr);
                end
            end
        end
    end

    // Issues one mul/div op, scrambles inputs while busy, measures busy width and latency.
    task automatic run_md(input string nm, input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [5:0] c, input logic [2:0] wr,
                          input logic [15:0] res);
        int busy_cnt = 0;
        int lat = 0;
        @(negedge clock);
        drive(op, 1'b0, a, b, 16'h0000, c, wr);
        push(res, b, c, wr);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clock);
            if (cyc == 1) drive(OP_ADD, 1'b0, ~a, ~b, 16'h5A5A, ~c, ~wr);
            if (busy) busy_cnt++;
            if (!busy && cyc > 1) inValid = 1'b0;
            if (outValid) begin
                lat = cyc - 1;
                break;
            end
        end
        inValid = 1'b0;
        chk({nm, "_latency"}, lat, 17);
        chk({nm, "_busy_cycles"}, busy_cnt, 16);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{OP_ADD, 1'b0, 16'h0003, 16'h0001, 16'h0000, 6'b000000, 3'd1, 16'h0004};
        vecs[1]  = '{OP_SUB, 1'b0, 16'h1234, 16'h1234, 16'h0000, 6'b010000, 3'd2, 16'h0000};
        vecs[2]  = '{OP_AND, 1'b0, 16'hF0F0, 16'h3C3C, 16'h0000, 6'b000010, 3'd3, 16'h3030};
        vecs[3]  = '{OP_OR,  1'b0, 16'hF0F0, 16'h0F0F, 16'h0000, 6'b100011, 3'd4, 16'hFFFF};
        vecs[4]  = '{OP_XOR, 1'b0, 16'hAAAA, 16'hFFFF, 16'h0000, 6'b001000, 3'd5, 16'h5555};
        vecs[5]  = '{OP_SLT, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 6'b000110, 3'd6, 16'h0001};
        vecs[6]  = '{OP_SLT, 1'b0, 16'h0001, 16'hFFFF, 16'h0000, 6'b000010, 3'd7, 16'h0000};
        vecs[7]  = '{OP_SLL, 1'b0, 16'h0001, 16'h0014, 16'h0000, 6'b000010, 3'd0, 16'h0010};
        vecs[8]  = '{OP_SRL, 1'b0, 16'h8000, 16'h000F, 16'h0000, 6'b000010, 3'd1, 16'h0001};
        vecs[9]  = '{OP_ADD, 1'b1, 16'h0010, 16'hBEEF, 16'hFFFF, 6'b010000, 3'd2, 16'h000F};
        vecs[10] = '{OP_ADD, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 6'b000010, 3'd3, 16'h0000};
        vecs[11] = '{4'd11,  1'b0, 16'h5555, 16'hAAAA, 16'h0000, 6'b000010, 3'd4, 16'h0000};
        vecs[12] = '{4'd15,  1'b0, 16'h1234, 16'h0001, 16'h0000, 6'b111111, 3'd5, 16'h0000};
        vecs[13] = '{OP_SUB, 1'b0, 16'h0000, 16'h0001, 16'h0000, 6'b000010, 3'd6, 16'hFFFF};
        vecs[14] = '{OP_SLL, 1'b0, 16'h1234, 16'h0010, 16'h0000, 6'b000010, 3'd7, 16'h1234};

        reset = 1'b1; inValid = 1'b0; flush = 1'b0; ALUSrc = 1'b0; ALUOp = '0;
        readData1 = '0; readData2 = '0; immediate = '0; ctrl_in = '0; writeReg = '0;
        repeat (2) @(negedge clock);
        chk("reset_outs", {busy, outValid, Zero, ctrl_o, writeRegOut, resultALU}, 32'h0);
        chk("reset_rd2", readData2Out, 16'h0000);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            drive(vecs[i].op, vecs[i].src, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].ctrl, vecs[i].wr);
            push(vecs[i].res, vecs[i].b, vecs[i].ctrl, vecs[i].wr);
        end
        @(negedge clock);
        inValid = 1'b0;
        @(negedge clock);
        chk("idle_no_valid", outValid, 1'b0);
        chk("idle_hold_result", resultALU, vecs[14].res);
        chk("table_drained", sb.size(), 0);

        run_md("mul",      OP_MUL,  16'h0101, 16'h0101, 6'b000010, 3'd1, 16'h0201);
        run_md("mul_max",  OP_MUL,  16'hFFFF, 16'hFFFF, 6'b000011, 3'd2, 16'h0001);
        run_md("divu",     OP_DIVU, 16'h0064, 16'h0007, 6'b000010, 3'd3, 16'h000E);
        run_md("remu",     OP_REMU, 16'h0064, 16'h0007, 6'b000010, 3'd4, 16'h0002);
        run_md("divu_z",   OP_DIVU, 16'h0064, 16'h0000, 6'b000010, 3'd5, 16'hFFFF);
        run_md("remu_z",   OP_REMU, 16'h0064, 16'h0000, 6'b000010, 3'd6, 16'h0064);
        run_md("remu_z8k", OP_REMU, 16'h8000, 16'h0000, 6'b000010, 3'd7, 16'h8000);

        // Flush during iteration 5 of a divide.
        @(negedge clock);
        drive(OP_DIVU, 1'b0, 16'h0064, 16'h0007, 16'h0000, 6'b000010, 3'd1);
        repeat (6) @(negedge clock);
        flush = 1'b1;
        drive(OP_ADD, 1'b0, 16'h1111, 16'h2222, 16'h0000, 6'b000010, 3'd2);
        @(posedge clock);
        #1;
        chk("flush_iter_busy", busy, 1'b0);
        chk("flush_iter_valid", outValid, 1'b0);
        @(negedge clock);
        flush = 1'b0;
        drive(OP_ADD, 1'b0, 16'h0005, 16'h0006, 16'h0000, 6'b100010, 3'd3);
        push(16'h000B, 16'h0006, 6'b100010, 3'd3);
        @(negedge clock);
        inValid = 1'b0;
        chk("add_after_flush_lat", outValid, 1'b1);
        run_md("divu_after_flush", OP_DIVU, 16'h0064, 16'h0007, 6'b000010, 3'd4, 16'h000E);

        // Flush in IDLE wins over a valid instruction.
        @(negedge clock);
        drive(OP_ADD, 1'b0, 16'h0001, 16'h0001, 16'h0000, 6'b000010, 3'd5);
        flush = 1'b1;
        @(negedge clock);
        inValid = 1'b0;
        flush = 1'b0;
        chk("flush_idle_valid", outValid, 1'b0);
        chk("flush_idle_result_held", resultALU, 16'h000E);

        // Asynchronous reset at iteration 8 of a multiply.
        @(negedge clock);
        drive(OP_MUL, 1'b0, 16'h0101, 16'h0101, 16'h0000, 6'b000010, 3'd6);
        push(16'h0201, 16'h0101, 6'b000010, 3'd6);
        repeat (9) @(negedge clock);
        inValid = 1'b0;
        chk("mul_busy_before_reset", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("async_reset_outs", {busy, outValid, Zero, ctrl_o, writeRegOut, resultALU}, 32'h0);
        chk("async_reset_rd2", readData2Out, 16'h0000);
        sb.delete();
        @(negedge clock);
        reset = 1'b0;
        repeat (25) @(negedge clock);
        chk("no_result_after_reset", sb.size(), 0);
        drive(OP_SLT, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 6'b000010, 3'd7);
        push(16'h0001, 16'h0001, 6'b000010, 3'd7);
        @(negedge clock);
        inValid = 1'b0;
        repeat (3) @(negedge clock);
        chk("final_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
